// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin front end for the SDRAM controller user interface.
// Writes are streamed into the controller write FIFO before their command is
// issued; read commands are tagged so returning words go back to their owner.
module sdram_port_arbiter #(
  parameter int ADR_W     = 25,
  parameter int LEN_W     = 10,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_fin,
  input  logic              p0_req,
  input  logic              p0_wr_rd,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [ADR_W-1:0]  p0_adr,
  output logic              p0_ack,
  output logic              p0_wready,
  input  logic              p0_wvalid,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_wmask,
  output logic              p0_rd_valid,
  output logic [DATA_W-1:0] p0_rd_data,
  input  logic              p1_req,
  input  logic              p1_wr_rd,
  input  logic [LEN_W-1:0]  p1_len,
  input  logic [ADR_W-1:0]  p1_adr,
  output logic              p1_ack,
  output logic              p1_wready,
  input  logic              p1_wvalid,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_wmask,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              cmd_en,
  output logic              cmd_wr_rd,
  output logic [LEN_W-1:0]  cmd_len,
  output logic [ADR_W-1:0]  cmd_adr,
  input  logic              cmd_av,
  input  logic [LEN_W-1:0]  wr_remain_space,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_mask,
  input  logic              rd_av,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data
);

  // TAG_DEPTH must be a power of two and at least 2
  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, ARB, WFILL, CMD} state_t;

  state_t              state_q;
  logic                last_q, owner_q, wr_rd_q;
  logic [LEN_W-1:0]    len_q, wcnt_q;
  logic [ADR_W-1:0]    adr_q;
  logic [1:0]          ack_q, wready_q;
  logic                cmd_en_q, wr_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [1:0]          wr_mask_q;

  logic                tag_own_q [TAG_DEPTH];
  logic [LEN_W-1:0]    tag_len_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      tcnt_q, tcnt_d;
  logic [LEN_W-1:0]    rcnt_q, rcnt_d;
  logic                rd_vld_q, rd_own_q;

  logic                tag_full, tag_empty, tag_push, tag_pop;
  logic                elig0, elig1, gnt_ok, gnt_sel;
  logic                sel_wr_rd;
  logic [LEN_W-1:0]    sel_len, wcnt_inc;
  logic [ADR_W-1:0]    sel_adr;
  logic                own_wvalid, accept;

  assign tag_full  = (tcnt_q == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty = (tcnt_q == '0);
  assign tag_push  = (state_q == CMD) & cmd_av & wr_rd_q;
  assign rd_en     = rd_av & ~tag_empty;
  assign tag_pop   = rd_en & ((rcnt_q + LEN_W'(1)) == tag_len_q[rptr_q]);

  // Eligibility and round-robin selection; no grant while an ack is in flight,
  // since the acked requester still holds req during the ack cycle.
  always_comb begin
    elig0      = p0_req & (p0_wr_rd ? ~tag_full : (wr_remain_space >= p0_len));
    elig1      = p1_req & (p1_wr_rd ? ~tag_full : (wr_remain_space >= p1_len));
    gnt_sel    = (elig0 & elig1) ? ~last_q : elig1;
    gnt_ok     = (state_q == ARB) & (ack_q == '0) & (elig0 | elig1);
    sel_wr_rd  = gnt_sel ? p1_wr_rd : p0_wr_rd;
    sel_len    = gnt_sel ? p1_len : p0_len;
    sel_adr    = gnt_sel ? p1_adr : p0_adr;
    own_wvalid = owner_q ? p1_wvalid : p0_wvalid;
    accept     = (state_q == WFILL) & own_wvalid & (|wready_q);
    wcnt_inc   = wcnt_q + LEN_W'(1);
  end

  // Command FSM with registered acks, write stream and controller command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      wr_rd_q   <= 1'b0;
      len_q     <= '0;
      adr_q     <= '0;
      wcnt_q    <= '0;
      ack_q     <= '0;
      wready_q  <= '0;
      cmd_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
    end else begin
      ack_q    <= '0;
      cmd_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      case (state_q)
        IDLE: if (init_fin) state_q <= ARB;
        ARB: begin
          if (gnt_ok) begin
            last_q  <= gnt_sel;
            owner_q <= gnt_sel;
            wr_rd_q <= sel_wr_rd;
            len_q   <= sel_len;
            adr_q   <= sel_adr;
            if (sel_len == '0) begin
              ack_q <= gnt_sel ? 2'b10 : 2'b01;
            end else if (sel_wr_rd) begin
              state_q <= CMD;
            end else begin
              wready_q <= gnt_sel ? 2'b10 : 2'b01;
              wcnt_q   <= '0;
              state_q  <= WFILL;
            end
          end
        end
        WFILL: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= owner_q ? p1_wdata : p0_wdata;
            wr_mask_q <= owner_q ? p1_wmask : p0_wmask;
            wcnt_q    <= wcnt_inc;
            if (wcnt_inc == len_q) begin
              wready_q <= '0;
              state_q  <= CMD;
            end
          end
        end
        CMD: begin
          if (cmd_av) begin
            cmd_en_q <= 1'b1;
            ack_q    <= owner_q ? 2'b10 : 2'b01;
            state_q  <= ARB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next tag count and pop-word counter
  always_comb begin
    tcnt_d = tcnt_q;
    case ({tag_push, tag_pop})
      2'b10:   tcnt_d = tcnt_q + (PTR_W+1)'(1);
      2'b01:   tcnt_d = tcnt_q - (PTR_W+1)'(1);
      default: tcnt_d = tcnt_q;
    endcase
    rcnt_d = tag_pop ? '0 : (rcnt_q + LEN_W'(1));
  end

  // Read tag FIFO and one-cycle-delayed return routing
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      tcnt_q   <= '0;
      rcnt_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_own_q[i] <= 1'b0;
        tag_len_q[i] <= '0;
      end
    end else begin
      if (tag_push) begin
        tag_own_q[wptr_q] <= owner_q;
        tag_len_q[wptr_q] <= len_q;
        wptr_q            <= wptr_q + PTR_W'(1);
      end
      if (rd_en)   rcnt_q <= rcnt_d;
      if (tag_pop) rptr_q <= rptr_q + PTR_W'(1);
      tcnt_q   <= tcnt_d;
      rd_vld_q <= rd_en;
      rd_own_q <= tag_own_q[rptr_q];
    end
  end

  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_wready   = wready_q[0];
  assign p1_wready   = wready_q[1];
  assign cmd_en      = cmd_en_q;
  assign cmd_wr_rd   = wr_rd_q;
  assign cmd_len     = len_q;
  assign cmd_adr     = adr_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign wr_mask     = wr_mask_q;
  assign p0_rd_valid = rd_vld_q & ~rd_own_q;
  assign p1_rd_valid = rd_vld_q & rd_own_q;
  assign p0_rd_data  = p0_rd_valid ? rd_data : '0;
  assign p1_rd_data  = p1_rd_valid ? rd_data : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: inputs driven and outputs sampled on
// the falling clock edge.
module tb_sdram_port_arbiter;
  localparam int ADR_W = 25, LEN_W = 10, DATA_W = 16, TAG_DEPTH = 4;

  logic clk = 1'b0;
  logic rst, init_fin;
  logic p0_req, p0_wr_rd, p0_ack, p0_wready, p0_wvalid, p0_rd_valid;
  logic [LEN_W-1:0] p0_len;
  logic [ADR_W-1:0] p0_adr;
  logic [DATA_W-1:0] p0_wdata, p0_rd_data;
  logic [1:0] p0_wmask;
  logic p1_req, p1_wr_rd, p1_ack, p1_wready, p1_wvalid, p1_rd_valid;
  logic [LEN_W-1:0] p1_len;
  logic [ADR_W-1:0] p1_adr;
  logic [DATA_W-1:0] p1_wdata, p1_rd_data;
  logic [1:0] p1_wmask;
  logic cmd_en, cmd_wr_rd, cmd_av, wr_en, rd_av, rd_en;
  logic [LEN_W-1:0] cmd_len, wr_remain_space;
  logic [ADR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [1:0] wr_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADR_W(ADR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst), .init_fin(init_fin),
    .p0_req(p0_req), .p0_wr_rd(p0_wr_rd), .p0_len(p0_len), .p0_adr(p0_adr), .p0_ack(p0_ack),
    .p0_wready(p0_wready), .p0_wvalid(p0_wvalid), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_req(p1_req), .p1_wr_rd(p1_wr_rd), .p1_len(p1_len), .p1_adr(p1_adr), .p1_ack(p1_ack),
    .p1_wready(p1_wready), .p1_wvalid(p1_wvalid), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .cmd_en(cmd_en), .cmd_wr_rd(cmd_wr_rd), .cmd_len(cmd_len), .cmd_adr(cmd_adr), .cmd_av(cmd_av),
    .wr_remain_space(wr_remain_space), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_av(rd_av), .rd_en(rd_en), .rd_data(rd_data)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_defaults();
    init_fin = 1'b1;
    p0_req = 0; p0_wr_rd = 0; p0_len = '0; p0_adr = '0; p0_wvalid = 0; p0_wdata = '0; p0_wmask = '0;
    p1_req = 0; p1_wr_rd = 0; p1_len = '0; p1_adr = '0; p1_wvalid = 0; p1_wdata = '0; p1_wmask = '0;
    cmd_av = 1'b1; wr_remain_space = 10'd1023; rd_av = 1'b0; rd_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_defaults();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    logic any_out, seen;
    int got;
    rst = 1'b1;
    set_defaults();
    init_fin = 1'b0; rd_av = 1'b1; rd_data = 16'hFFFF;
    repeat (2) tick();
    #1;
    any_out = p0_ack | p1_ack | p0_wready | p1_wready | p0_rd_valid | p1_rd_valid |
              (|p0_rd_data) | (|p1_rd_data) | cmd_en | cmd_wr_rd | (|cmd_len) | (|cmd_adr) |
              wr_en | (|wr_data) | (|wr_mask) | rd_en;
    n_tests++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: some output nonzero, expected all 0"); end
    rst = 1'b0; rd_av = 1'b0; rd_data = '0;
    p0_req = 1; p0_wr_rd = 1; p0_len = 10'd1; p0_adr = 25'd5;
    seen = 1'b0;
    repeat (10) begin tick(); seen = seen | p0_ack | cmd_en; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL no_grant_before_init: got ack/cmd, expected none"); end
    init_fin = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (p0_ack) begin
        got = 1;
        n_tests++;
        if ({cmd_en, cmd_wr_rd, cmd_len, cmd_adr} !== {1'b1, 1'b1, 10'd1, 25'd5}) begin
          n_fail++; $display("FAIL init_cmd: got en=%b wr_rd=%b len=%0d adr=%0h expected 1 1 1 5", cmd_en, cmd_wr_rd, cmd_len, cmd_adr);
        end
      end
    end
    p0_req = 0;
    n_tests++;
    if (got !== 1) begin n_fail++; $display("FAIL grant_after_init: got no ack, expected ack"); end
  endtask

  task automatic test_write();
    logic [15:0] w[3];
    logic [1:0]  m[3];
    int idx, nwr, ncmd, nack, nack1, wr_at_cmd;
    logic pend, gapped;
    w = '{16'hAAAA, 16'hFFFF, 16'h0000};
    m = '{2'b00, 2'b01, 2'b10};
    do_reset();
    p0_req = 1; p0_wr_rd = 0; p0_len = 10'd3; p0_adr = '0;
    p0_wvalid = 1; p0_wdata = w[0]; p0_wmask = m[0];
    idx = 0; pend = 0; gapped = 0; nwr = 0; ncmd = 0; nack = 0; nack1 = 0; wr_at_cmd = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wr_en) begin
        n_tests++;
        if (nwr >= 3) begin
          n_fail++; $display("FAIL write_extra: got wr_en word %0d, expected 3 words", nwr);
        end else if (wr_data !== w[nwr] || wr_mask !== m[nwr]) begin
          n_fail++; $display("FAIL write_word%0d: got %h/%b expected %h/%b", nwr, wr_data, wr_mask, w[nwr], m[nwr]);
        end
        nwr++;
      end
      if (cmd_en) begin
        ncmd++; wr_at_cmd = nwr;
        n_tests++;
        if ({cmd_wr_rd, cmd_len, cmd_adr, p0_ack} !== {1'b0, 10'd3, 25'd0, 1'b1}) begin
          n_fail++; $display("FAIL write_cmd: got wr_rd=%b len=%0d adr=%0h ack=%b expected 0 3 0 1", cmd_wr_rd, cmd_len, cmd_adr, p0_ack);
        end
      end
      if (p0_ack) begin nack++; p0_req = 0; end
      if (p1_ack) nack1++;
      if (pend) idx++;
      if (idx == 1 && !gapped) begin
        p0_wvalid = 0; gapped = 1;
      end else if (idx < 3) begin
        p0_wvalid = 1; p0_wdata = w[idx]; p0_wmask = m[idx];
      end else begin
        p0_wvalid = 0;
      end
      pend = p0_wready & p0_wvalid;
    end
    n_tests++;
    if (nwr !== 3) begin n_fail++; $display("FAIL write_count: got %0d expected 3", nwr); end
    n_tests++;
    if (ncmd !== 1 || wr_at_cmd !== 3) begin n_fail++; $display("FAIL write_cmd_once: got %0d cmds after %0d words, expected 1 after 3", ncmd, wr_at_cmd); end
    n_tests++;
    if (nack !== 1 || nack1 !== 0) begin n_fail++; $display("FAIL write_ack: got p0=%0d p1=%0d expected 1 0", nack, nack1); end
  endtask

  task automatic test_read_two();
    logic [15:0] rw[6];
    int popped, delivered, p0cnt, p1cnt, first_owner, ncmd, both;
    logic pop_prev;
    rw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    do_reset();
    rd_av = 1; #1;
    n_tests++;
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rd_en_untagged: got %b expected 0", rd_en); end
    p0_req = 1; p0_wr_rd = 1; p0_len = 10'd3; p0_adr = 25'h0;
    p1_req = 1; p1_wr_rd = 1; p1_len = 10'd3; p1_adr = 25'h1000000;
    popped = 0; delivered = 0; p0cnt = 0; p1cnt = 0; first_owner = -1; ncmd = 0; both = 0; pop_prev = 0;
    for (int c = 0; c < 80 && (p0cnt + p1cnt) < 6; c++) begin
      tick();
      if (pop_prev) begin rd_data = rw[delivered]; delivered++; end
      else rd_data = 16'hDEAD;
      #1;
      if (p0_rd_valid && p1_rd_valid) both++;
      if (p0_rd_valid) begin
        n_tests++;
        if (p0cnt >= 3 || p0_rd_data !== rw[p0cnt]) begin
          n_fail++; $display("FAIL p0_read%0d: got %h expected %h", p0cnt, p0_rd_data, (p0cnt < 3) ? rw[p0cnt] : 16'h0);
        end
        p0cnt++;
      end
      if (p1_rd_valid) begin
        n_tests++;
        if (p1cnt >= 3 || p1_rd_data !== rw[3 + (p1cnt % 3)]) begin
          n_fail++; $display("FAIL p1_read%0d: got %h expected %h", p1cnt, p1_rd_data, rw[3 + (p1cnt % 3)]);
        end
        p1cnt++;
      end
      if (cmd_en) begin
        ncmd++;
        if (first_owner < 0) first_owner = (cmd_adr != 25'h0) ? 1 : 0;
      end
      if (p0_ack) p0_req = 0;
      if (p1_ack) p1_req = 0;
      rd_av = (popped < 6);
      #1;
      pop_prev = rd_en;
      if (rd_en) popped++;
    end
    rd_av = 0;
    n_tests++;
    if (first_owner !== 0 || ncmd !== 2) begin n_fail++; $display("FAIL read_cmd_order: got first=%0d cmds=%0d expected 0 2", first_owner, ncmd); end
    n_tests++;
    if (p0cnt !== 3 || p1cnt !== 3 || both !== 0) begin n_fail++; $display("FAIL read_routing: got p0=%0d p1=%0d both=%0d expected 3 3 0", p0cnt, p1cnt, both); end
  endtask

  task automatic test_rr();
    logic seq[4];
    int nack, both;
    do_reset();
    p0_req = 1; p0_wr_rd = 1; p0_len = 10'd1; p0_adr = 25'h10;
    p1_req = 1; p1_wr_rd = 1; p1_len = 10'd1; p1_adr = 25'h20;
    nack = 0; both = 0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      tick();
      if (p0_ack && p1_ack) both++;
      if (p0_ack) begin seq[nack] = 1'b0; nack++; end
      else if (p1_ack) begin seq[nack] = 1'b1; nack++; end
    end
    p0_req = 0; p1_req = 0;
    n_tests++;
    if (nack !== 4 || both !== 0) begin n_fail++; $display("FAIL rr_acks: got %0d acks both=%0d expected 4 0", nack, both); end
    for (int i = 0; i < 4 && i < nack; i++) begin
      n_tests++;
      if (seq[i] !== ((i % 2) == 1)) begin n_fail++; $display("FAIL rr_order%0d: got port %0d expected %0d", i, seq[i], i % 2); end
    end
  endtask

  task automatic test_cmd_av();
    logic seen;
    int extra;
    do_reset();
    cmd_av = 0;
    p0_req = 1; p0_wr_rd = 1; p0_len = 10'd2; p0_adr = 25'h123;
    seen = 0;
    repeat (20) begin tick(); seen = seen | cmd_en | p0_ack; end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL cmd_av_hold: got cmd/ack while cmd_av=0, expected none"); end
    cmd_av = 1;
    tick();
    n_tests++;
    if ({cmd_en, cmd_wr_rd, cmd_len, cmd_adr, p0_ack} !== {1'b1, 1'b1, 10'd2, 25'h123, 1'b1}) begin
      n_fail++; $display("FAIL cmd_av_release: got en=%b wr_rd=%b len=%0d adr=%0h ack=%b expected 1 1 2 123 1", cmd_en, cmd_wr_rd, cmd_len, cmd_adr, p0_ack);
    end
    p0_req = 0;
    extra = 0;
    repeat (5) begin tick(); if (cmd_en) extra++; end
    n_tests++;
    if (extra !== 0) begin n_fail++; $display("FAIL cmd_single_pulse: got %0d extra pulses expected 0", extra); end
  endtask

  task automatic test_tag_full();
    int nack, extra, got;
    do_reset();
    p0_req = 1; p0_wr_rd = 1; p0_len = 10'd1; p0_adr = 25'h0;
    nack = 0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      tick();
      if (p0_ack) begin nack++; p0_adr = p0_adr + 25'd1; end
    end
    n_tests++;
    if (nack !== 4) begin n_fail++; $display("FAIL tag_fill: got %0d acks expected 4", nack); end
    extra = 0;
    repeat (20) begin tick(); if (p0_ack) extra++; end
    n_tests++;
    if (extra !== 0) begin n_fail++; $display("FAIL tag_full_block: got %0d acks expected 0", extra); end
    rd_av = 1; #1;
    n_tests++;
    if (rd_en !== 1'b1) begin n_fail++; $display("FAIL tag_pop_en: got %b expected 1", rd_en); end
    tick();
    rd_av = 0; rd_data = 16'hBEEF; #1;
    n_tests++;
    if ({p0_rd_valid, p1_rd_valid, p0_rd_data} !== {1'b1, 1'b0, 16'hBEEF}) begin
      n_fail++; $display("FAIL tag_pop_data: got v0=%b v1=%b d=%h expected 1 0 beef", p0_rd_valid, p1_rd_valid, p0_rd_data);
    end
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin tick(); if (p0_ack) got = 1; end
    p0_req = 0;
    n_tests++;
    if (got !== 1) begin n_fail++; $display("FAIL tag_retire_grant: got no 5th ack, expected ack"); end
  endtask

  task automatic test_len0();
    logic bad;
    do_reset();
    p0_req = 1; p0_wr_rd = 0; p0_len = '0; p0_adr = 25'd7;
    tick();
    n_tests++;
    if ({p0_ack, cmd_en, wr_en} !== 3'b100) begin
      n_fail++; $display("FAIL len0_ack: got ack=%b cmd_en=%b wr_en=%b expected 1 0 0", p0_ack, cmd_en, wr_en);
    end
    p0_req = 0;
    bad = 0;
    repeat (10) begin tick(); bad = bad | cmd_en | wr_en | p0_wready | p0_ack | p1_ack; end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL len0_quiet: got activity, expected none"); end
  endtask

  task automatic test_space();
    logic bad, pend;
    int idx, nwr, ncmd, nack;
    do_reset();
    wr_remain_space = 10'd5;
    p0_req = 1; p0_wr_rd = 0; p0_len = 10'd8; p0_adr = 25'h40;
    p0_wvalid = 1; p0_wdata = 16'h0100; p0_wmask = 2'b11;
    bad = 0;
    repeat (10) begin tick(); bad = bad | p0_wready | p0_ack | cmd_en | wr_en; end
    wr_remain_space = 10'd7;
    repeat (10) begin tick(); bad = bad | p0_wready | p0_ack | cmd_en | wr_en; end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL space_block: got grant with space<8, expected none"); end
    wr_remain_space = 10'd8;
    idx = 0; pend = 0; nwr = 0; ncmd = 0; nack = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (wr_en) begin
        n_tests++;
        if (wr_data !== 16'h0100 + 16'(nwr)) begin
          n_fail++; $display("FAIL space_word%0d: got %h expected %h", nwr, wr_data, 16'h0100 + 16'(nwr));
        end
        nwr++;
      end
      if (cmd_en) begin
        ncmd++;
        n_tests++;
        if ({cmd_wr_rd, cmd_len, cmd_adr} !== {1'b0, 10'd8, 25'h40}) begin
          n_fail++; $display("FAIL space_cmd: got wr_rd=%b len=%0d adr=%0h expected 0 8 40", cmd_wr_rd, cmd_len, cmd_adr);
        end
      end
      if (p0_ack) begin nack++; p0_req = 0; end
      if (pend) idx++;
      if (idx < 8) p0_wdata = 16'h0100 + 16'(idx);
      else p0_wvalid = 0;
      pend = p0_wready & p0_wvalid;
    end
    n_tests++;
    if (nwr !== 8 || ncmd !== 1 || nack !== 1) begin
      n_fail++; $display("FAIL space_totals: got words=%0d cmds=%0d acks=%0d expected 8 1 1", nwr, ncmd, nack);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_two();
    test_rr();
    test_cmd_av();
    test_tag_full();
    test_len0();
    test_space();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
